// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and block memory.
// Latency: hits complete in the request cycle (0 stalls); a miss stalls 1 detect cycle + WB ack time (if dirty) + FILL ack time.
// Backpressure: stall_o freezes the pipeline until the held request hits; memory side waits for a one-cycle mem_ack_i pulse.
module dcache_controller #(
   parameter int LINES   = 16,
   parameter int BLOCK_W = 256,
   parameter int ADDR_W  = 32
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               MemRead_i,
   input  logic               MemWrite_i,
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [31:0]        data_i,
   output logic [31:0]        data_o,
   output logic               stall_o,
   output logic               mem_req_o,
   output logic               mem_write_o,
   output logic [ADDR_W-1:0]  mem_addr_o,
   output logic [BLOCK_W-1:0] mem_data_o,
   input  logic [BLOCK_W-1:0] mem_data_i,
   input  logic               mem_ack_i
);

   localparam int OFF_W  = $clog2(BLOCK_W / 8);
   localparam int WORD_W = $clog2(BLOCK_W / 32);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

   state_t state_q, state_d;

   // Line state: valid/dirty live in flops so reset empties the cache at once;
   // tags and data need no reset because valid gates every use of them.
   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [BLOCK_W-1:0] data_q [LINES];

   // The miss target is captured when the miss is detected so the memory-side
   // address stays put even if the CPU withdraws the request mid-miss.
   logic [IDX_W-1:0]   miss_idx_q;
   logic [TAG_W-1:0]   miss_tag_q;

   logic [WORD_W-1:0]  word;
   logic [IDX_W-1:0]   index;
   logic [TAG_W-1:0]   tag;
   logic               unused_addr;
   logic               req;
   logic               hit;
   logic               hit_ok;
   logic               wr_hit;
   logic               start_miss;
   logic               fill_done;
   logic [BLOCK_W-1:0] line_blk;

   assign word        = addr_i[OFF_W-1:2];
   assign index       = addr_i[OFF_W+IDX_W-1:OFF_W];
   assign tag         = addr_i[ADDR_W-1:OFF_W+IDX_W];
   assign unused_addr = ^addr_i[1:0];

   assign req        = MemRead_i | MemWrite_i;
   assign hit        = req & valid_q[index] & (tag_q[index] == tag);
   // Hits are only served from IDLE; during WB/FILL the held request is by
   // construction still a miss and must keep stalling.
   assign hit_ok     = (state_q == S_IDLE) & hit;
   assign wr_hit     = hit_ok & MemWrite_i;
   assign start_miss = (state_q == S_IDLE) & req & ~hit;
   assign fill_done  = (state_q == S_FILL) & mem_ack_i;

   assign line_blk = data_q[index];
   assign data_o   = hit_ok ? line_blk[{word, 5'b0} +: 32] : 32'd0;
   assign stall_o  = req & ~hit_ok;

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and memory-side outputs; outputs are decoded from state only
   // so mem_req_o falls together with an asynchronous reset.
   always_comb begin
      state_d     = state_q;
      mem_req_o   = 1'b0;
      mem_write_o = 1'b0;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      case (state_q)
         S_IDLE: begin
            if (start_miss) begin
               state_d = (valid_q[index] & dirty_q[index]) ? S_WB : S_FILL;
            end
         end
         S_WB: begin
            mem_req_o   = 1'b1;
            mem_write_o = 1'b1;
            mem_addr_o  = {tag_q[miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
            mem_data_o  = data_q[miss_idx_q];
            if (mem_ack_i) state_d = S_FILL;
         end
         S_FILL: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
            if (mem_ack_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Capture the missing line's index and tag on miss detection.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         miss_idx_q <= '0;
         miss_tag_q <= '0;
      end else if (start_miss) begin
         miss_idx_q <= index;
         miss_tag_q <= tag;
      end
   end

   // Valid/dirty bookkeeping: write-back cleans, fill validates clean, store hit dirties.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if ((state_q == S_WB) && mem_ack_i) dirty_q[miss_idx_q] <= 1'b0;
         if (fill_done) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
         end
         if (wr_hit) dirty_q[index] <= 1'b1;
      end
   end

   // Tag/data arrays: whole-block install on fill, single-word update on store hit.
   always_ff @(posedge clk_i) begin
      if (fill_done) begin
         data_q[miss_idx_q] <= mem_data_i;
         tag_q[miss_idx_q]  <= miss_tag_q;
      end else if (wr_hit) begin
         data_q[index][{word, 5'b0} +: 32] <= data_i;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with scoreboarded CPU and memory responses.
// Stimulus pushes expected completions/transactions; two monitors pop and compare.
// A behavioural memory answers mem_req_o after a programmable number of cycles.
module tb_dcache_controller;

   typedef struct {
      bit          is_read;
      logic [31:0] data;
      int          stalls;
   } cpu_exp_t;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] blk;
   } mem_exp_t;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         MemRead_i = 1'b0;
   logic         MemWrite_i = 1'b0;
   logic [31:0]  addr_i = '0;
   logic [31:0]  data_i = '0;
   logic [31:0]  data_o;
   logic         stall_o;
   logic         mem_req_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i = '0;
   logic         mem_ack_i;
   logic         resp_ack = 1'b0;
   logic         spur_ack = 1'b0;

   int total = 0;
   int bad = 0;
   int ack_lat = 1;

   cpu_exp_t cpu_q [$];
   mem_exp_t mem_q [$];
   logic [255:0] mem_model [logic [31:0]];

   assign mem_ack_i = resp_ack | spur_ack;

   dcache_controller #(.LINES(16), .BLOCK_W(256), .ADDR_W(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .MemRead_i   (MemRead_i),
      .MemWrite_i  (MemWrite_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_write_o (mem_write_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .mem_data_i  (mem_data_i),
      .mem_ack_i   (mem_ack_i)
   );

   initial forever #5 clk_i = ~clk_i;

   // Initial memory image: word j of block A holds A + 4*j + 5.
   function automatic logic [255:0] mk_block(input logic [31:0] a);
      logic [255:0] b;
      b = '0;
      for (int j = 0; j < 8; j++) b[j*32 +: 32] = a + 32'(4 * j) + 32'd5;
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_mem(input bit wr, input logic [31:0] a, input logic [255:0] b);
      mem_exp_t e;
      e.wr = wr;
      e.addr = a;
      e.blk = b;
      mem_q.push_back(e);
   endtask

   // Issue one CPU access, hold it until stall_o drops, then release it.
   task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp, input int stalls);
      cpu_exp_t e;
      bit done;
      e.is_read = rd && !wr;
      e.data = exp;
      e.stalls = stalls;
      cpu_q.push_back(e);
      done = 1'b0;
      @(posedge clk_i); #1;
      MemRead_i = rd;
      MemWrite_i = wr;
      addr_i = a;
      data_i = wd;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk_i);
         if (!stall_o) done = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL access_timeout: addr 0x%0h still stalled after 200 cycles", a);
      end
      @(posedge clk_i); #1;
      MemRead_i = 1'b0;
      MemWrite_i = 1'b0;
   endtask

   // Memory responder: acks in the ack_lat-th cycle of a request.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            resp_ack = 1'b0;
            cnt = 0;
         end else begin
            if (resp_ack) begin
               resp_ack = 1'b0;
               cnt = 0;
            end
            if (mem_req_o) begin
               cnt++;
               if (cnt >= ack_lat) begin
                  resp_ack = 1'b1;
                  if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
                  else if (mem_model.exists(mem_addr_o)) mem_data_i = mem_model[mem_addr_o];
                  else mem_data_i = mk_block(mem_addr_o);
               end
            end
         end
      end
   end

   // CPU-side monitor: counts stall cycles and checks each completed access.
   initial begin
      int scnt;
      cpu_exp_t e;
      scnt = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            scnt = 0;
         end else if (MemRead_i || MemWrite_i) begin
            if (stall_o) begin
               scnt++;
            end else if (cpu_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL cpu_unexpected: completion at addr 0x%0h with no expectation", addr_i);
            end else begin
               e = cpu_q.pop_front();
               chk("stall_cycles", 32'(scnt), 32'(e.stalls));
               if (e.is_read) chk("load_data", data_o, e.data);
               scnt = 0;
            end
         end
      end
   end

   // Memory-side monitor: checks every acknowledged transaction.
   initial begin
      mem_exp_t e;
      forever begin
         @(negedge clk_i); #1;
         if (rst_i && mem_req_o && mem_ack_i) begin
            if (mem_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL mem_unexpected: write=%0d addr=0x%0h", mem_write_o, mem_addr_o);
            end else begin
               e = mem_q.pop_front();
               chk("mem_write", 32'(mem_write_o), 32'(e.wr));
               chk("mem_addr", mem_addr_o, e.addr);
               if (e.wr) chkb("wb_block", mem_data_o, e.blk);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      logic [255:0] wb;
      bit seen;

      #1 rst_i = 1'b0;
      #2;
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_mem_write", 32'(mem_write_o), 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chkb("rst_mem_data", mem_data_o, 256'd0);
      chk("rst_data_o", data_o, 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(negedge clk_i);
      chk("idle_data_o", data_o, 32'd0);
      chk("idle_stall", 32'(stall_o), 32'd0);

      // Cold load: FILL acked in its 3rd cycle.
      ack_lat = 3;
      exp_mem(1'b0, 32'h000, '0);
      access(1'b1, 1'b0, 32'h000, 32'd0, 32'd5, 4);

      // Store hit then loads, no memory traffic.
      access(1'b0, 1'b1, 32'h004, 32'hDEAD, 32'd0, 0);
      access(1'b1, 1'b0, 32'h004, 32'd0, 32'hDEAD, 0);
      access(1'b1, 1'b0, 32'h008, 32'd0, 32'h0D, 0);

      // Dirty eviction of index 0, then clean refill of the written-back block.
      ack_lat = 2;
      wb = mk_block(32'h000);
      wb[63:32] = 32'hDEAD;
      exp_mem(1'b1, 32'h000, wb);
      exp_mem(1'b0, 32'h200, '0);
      access(1'b1, 1'b0, 32'h200, 32'd0, 32'h205, 5);
      ack_lat = 1;
      exp_mem(1'b0, 32'h000, '0);
      access(1'b1, 1'b0, 32'h004, 32'd0, 32'hDEAD, 2);

      // Clean conflict miss: FILL only.
      ack_lat = 4;
      exp_mem(1'b0, 32'h200, '0);
      access(1'b1, 1'b0, 32'h200, 32'd0, 32'h205, 5);

      // Read and write together behaves as a write.
      access(1'b1, 1'b1, 32'h208, 32'h1234, 32'd0, 0);
      access(1'b1, 1'b0, 32'h208, 32'd0, 32'h1234, 0);

      // Another index, and a write miss (write-allocate).
      ack_lat = 1;
      exp_mem(1'b0, 32'h020, '0);
      access(1'b1, 1'b0, 32'h024, 32'd0, 32'h29, 2);
      exp_mem(1'b0, 32'h0A0, '0);
      access(1'b0, 1'b1, 32'h0A4, 32'hCAFE, 32'd0, 2);
      access(1'b1, 1'b0, 32'h0A4, 32'd0, 32'hCAFE, 0);

      // No request: data_o zero, no stall.
      @(posedge clk_i); #1;
      addr_i = 32'h004;
      @(negedge clk_i);
      chk("noreq_data_o", data_o, 32'd0);
      chk("noreq_stall", 32'(stall_o), 32'd0);

      // Reset in the middle of a FILL.
      ack_lat = 10;
      @(posedge clk_i); #1;
      MemRead_i = 1'b1;
      addr_i = 32'h040;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_i);
         if (mem_req_o) seen = 1'b1;
      end
      chk("fill_req_seen", 32'(seen), 32'd1);
      chk("fill_addr", mem_addr_o, 32'h040);
      chk("fill_is_read", 32'(mem_write_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      #1;
      chk("midrst_mem_req", 32'(mem_req_o), 32'd0);
      chk("midrst_mem_addr", mem_addr_o, 32'd0);
      MemRead_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      ack_lat = 2;
      exp_mem(1'b0, 32'h000, '0);
      access(1'b1, 1'b0, 32'h000, 32'd0, 32'd5, 3);
      access(1'b1, 1'b0, 32'h004, 32'd0, 32'hDEAD, 0);

      // Spurious ack in IDLE must not validate anything.
      @(posedge clk_i); #1;
      addr_i = 32'h060;
      spur_ack = 1'b1;
      @(posedge clk_i); #1;
      spur_ack = 1'b0;
      chk("spur_mem_req", 32'(mem_req_o), 32'd0);
      ack_lat = 1;
      exp_mem(1'b0, 32'h060, '0);
      access(1'b1, 1'b0, 32'h060, 32'd0, 32'h65, 2);
      access(1'b1, 1'b0, 32'h000, 32'd0, 32'd5, 0);

      repeat (5) @(posedge clk_i);
      chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
      chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
